// File: rtl/plic_claim_agent.sv
// rtl/plic_claim_agent.sv - PLIC target-side agent: claim over the register bus, dispatch to a handler, complete
// Every bus and handler output is decoded from registered state and id_q only.
module plic_claim_agent #(
    parameter logic [31:0] CcAddr        = 32'h0C20_0004,
    parameter int          AddrWidth     = 32,
    parameter int          DataWidth     = 32,
    parameter int          SrcWidth      = 7,
    parameter int          HoldoffCycles = 2,
    parameter int          CntWidth      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   irq_i,
    output logic [AddrWidth-1:0]   reg_addr_o,
    output logic                   reg_write_o,
    output logic [DataWidth-1:0]   reg_wdata_o,
    output logic [DataWidth/8-1:0] reg_wstrb_o,
    output logic                   reg_valid_o,
    input  logic [DataWidth-1:0]   reg_rdata_i,
    input  logic                   reg_error_i,
    input  logic                   reg_ready_i,
    output logic                   hdl_valid_o,
    output logic [SrcWidth-1:0]    hdl_id_o,
    input  logic                   hdl_ready_i,
    input  logic                   done_i,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [CntWidth-1:0]    claim_cnt_o,
    output logic [CntWidth-1:0]    spurious_cnt_o
);

    typedef enum logic [2:0] {
        IDLE, CLAIM, DISPATCH, HANDLE, COMPLETE, HOLDOFF
    } state_e;

    state_e                state_q, state_d;
    logic [SrcWidth-1:0]   id_q, id_d;
    logic [3:0]            hold_q, hold_d;
    logic                  err_q, err_d;
    logic [CntWidth-1:0]   claim_q, claim_d;
    logic [CntWidth-1:0]   spur_q, spur_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
            claim_q <= '0;
            spur_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            claim_q <= claim_d;
            spur_q  <= spur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        hold_d  = hold_q;
        err_d   = err_q;
        claim_d = claim_q;
        spur_d  = spur_q;
        case (state_q)
            IDLE: begin
                if (irq_i && enable_i) state_d = CLAIM;
            end
            CLAIM: begin
                if (reg_ready_i) begin
                    if (reg_error_i) begin
                        err_d   = 1'b1;
                        state_d = HOLDOFF;
                        hold_d  = 4'(HoldoffCycles);
                    end else if (reg_rdata_i[SrcWidth-1:0] == '0) begin
                        if (spur_q != '1) spur_d = spur_q + 1'b1;
                        state_d = HOLDOFF;
                        hold_d  = 4'(HoldoffCycles);
                    end else begin
                        id_d    = reg_rdata_i[SrcWidth-1:0];
                        if (claim_q != '1) claim_d = claim_q + 1'b1;
                        state_d = DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                if (hdl_ready_i) state_d = HANDLE;
            end
            HANDLE: begin
                if (done_i) state_d = COMPLETE;
            end
            COMPLETE: begin
                // A failed completion is not retried; the ID is dropped.
                if (reg_ready_i) begin
                    if (reg_error_i) err_d = 1'b1;
                    state_d = HOLDOFF;
                    hold_d  = 4'(HoldoffCycles);
                end
            end
            HOLDOFF: begin
                hold_d = hold_q - 1'b1;
                if (hold_q <= 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_addr_o  = CcAddr[AddrWidth-1:0];
        reg_valid_o = (state_q == CLAIM) || (state_q == COMPLETE);
        reg_write_o = (state_q == COMPLETE);
        reg_wdata_o = '0;
        reg_wstrb_o = '0;
        if (state_q == COMPLETE) begin
            reg_wdata_o[SrcWidth-1:0] = id_q;
            reg_wstrb_o               = '1;
        end
        hdl_valid_o    = (state_q == DISPATCH);
        hdl_id_o       = id_q;
        busy_o         = (state_q != IDLE);
        err_o          = err_q;
        claim_cnt_o    = claim_q;
        spurious_cnt_o = spur_q;
    end

endmodule

// File: tb/tb_plic_claim_agent.sv
// tb/tb_plic_claim_agent.sv - directed vector bench for plic_claim_agent
// Counters are 2 bits wide here so saturation is reachable.
module tb_plic_claim_agent;

    localparam logic [31:0] CC = 32'h0C20_0004;

    logic        clk = 1'b0;
    logic        rst, enable, irq;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        reg_write, reg_valid, reg_error, reg_ready;
    logic [3:0]  reg_wstrb;
    logic        hdl_valid, hdl_ready, done, busy, err;
    logic [6:0]  hdl_id;
    logic [1:0]  claim_cnt, spur_cnt;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    plic_claim_agent #(.CcAddr(CC), .AddrWidth(32), .DataWidth(32), .SrcWidth(7),
                       .HoldoffCycles(2), .CntWidth(2)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .irq_i(irq),
        .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
        .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid), .reg_rdata_i(reg_rdata),
        .reg_error_i(reg_error), .reg_ready_i(reg_ready),
        .hdl_valid_o(hdl_valid), .hdl_id_o(hdl_id), .hdl_ready_i(hdl_ready),
        .done_i(done), .busy_o(busy), .err_o(err),
        .claim_cnt_o(claim_cnt), .spurious_cnt_o(spur_cnt)
    );

    always @(posedge clk) begin
        if (!rst && reg_valid && reg_ready) begin
            if (reg_write) wr_cnt <= wr_cnt + 1;
            else           rd_cnt <= rd_cnt + 1;
        end
    end

    typedef struct {
        logic        irq, en;
        logic [31:0] rdata;
        logic        rerr, rrdy, hrdy, dn;
        logic        ev, ew;
        logic [31:0] ewd;
        logic        ehv;
        logic [6:0]  eid;
        logic        ebusy, eerr;
        logic [1:0]  ec, es;
    } vec_t;

    vec_t vt[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        irq = 0; reg_rdata = 0; reg_error = 0; reg_ready = 0; hdl_ready = 0; done = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Zero-wait transaction from IDLE; cerr injects an error on the complete write.
    task automatic do_txn(input logic [6:0] id, input logic cerr);
        irq = 1; enable = 1;
        step();
        irq = 0;
        check("txn_claim_valid", {31'd0, reg_valid}, 32'd1);
        reg_ready = 1; reg_rdata = {25'd0, id};
        step();
        reg_ready = 0; hdl_ready = 1;
        check("txn_hdl_id", {25'd0, hdl_id}, {25'd0, id});
        step();
        hdl_ready = 0; done = 1;
        step();
        done = 0;
        check("txn_wdata", reg_wdata, {25'd0, id});
        reg_ready = 1; reg_error = cerr;
        step();
        reg_ready = 0; reg_error = 0;
        wait_idle("txn_back_idle");
    endtask

    initial begin
        int rd0, wr0, vcyc;
        //            irq en rdata          re rr hr dn  ev ew ewd hv eid bsy er ec es
        vt[0]  = '{0, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 32'h0,          0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 32'h5,          0, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[3]  = '{0, 1, 32'h0,          0, 0, 1, 0,  0, 0, 0, 1, 5, 1, 0, 1, 0};
        vt[4]  = '{0, 1, 32'h0,          0, 0, 0, 1,  0, 0, 0, 0, 5, 1, 0, 1, 0};
        vt[5]  = '{0, 1, 32'h0,          0, 1, 0, 0,  1, 1, 5, 0, 5, 1, 0, 1, 0};
        vt[6]  = '{1, 1, 32'h0,          0, 0, 0, 1,  0, 0, 0, 0, 5, 1, 0, 1, 0};
        vt[7]  = '{1, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 1, 0, 1, 0};
        vt[8]  = '{1, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 0, 0, 1, 0};
        vt[9]  = '{1, 1, 32'hFFFF_FF80,  0, 1, 0, 0,  1, 0, 0, 0, 5, 1, 0, 1, 0};
        vt[10] = '{1, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 1, 0, 1, 1};
        vt[11] = '{1, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 1, 0, 1, 1};
        vt[12] = '{1, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 0, 0, 1, 1};
        vt[13] = '{0, 1, 32'h9,          1, 1, 0, 0,  1, 0, 0, 0, 5, 1, 0, 1, 1};
        vt[14] = '{0, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 1, 1, 1, 1};
        vt[15] = '{0, 1, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 1, 1, 1, 1};
        vt[16] = '{1, 0, 32'h0,          0, 0, 0, 0,  0, 0, 0, 0, 5, 0, 1, 1, 1};

        rst = 1; enable = 1;
        idle_inputs();
        step();
        step();
        check("rst_valid", {31'd0, reg_valid}, 32'd0);
        check("rst_addr", reg_addr, CC);
        check("rst_wstrb", {28'd0, reg_wstrb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 0;

        for (int i = 0; i < 17; i++) begin
            irq = vt[i].irq; enable = vt[i].en; reg_rdata = vt[i].rdata;
            reg_error = vt[i].rerr; reg_ready = vt[i].rrdy;
            hdl_ready = vt[i].hrdy; done = vt[i].dn;
            check($sformatf("v%0d_valid", i), {31'd0, reg_valid}, {31'd0, vt[i].ev});
            check($sformatf("v%0d_write", i), {31'd0, reg_write}, {31'd0, vt[i].ew});
            check($sformatf("v%0d_wdata", i), reg_wdata, vt[i].ewd);
            check($sformatf("v%0d_wstrb", i), {28'd0, reg_wstrb}, vt[i].ew ? 32'hF : 32'h0);
            check($sformatf("v%0d_hvalid", i), {31'd0, hdl_valid}, {31'd0, vt[i].ehv});
            check($sformatf("v%0d_hid", i), {25'd0, hdl_id}, {25'd0, vt[i].eid});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].ebusy});
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].eerr});
            check($sformatf("v%0d_ccnt", i), {30'd0, claim_cnt}, {30'd0, vt[i].ec});
            check($sformatf("v%0d_scnt", i), {30'd0, spur_cnt}, {30'd0, vt[i].es});
            step();
        end
        idle_inputs();

        // Disabled with a pending interrupt: no bus traffic at all.
        irq = 1; enable = 0; vcyc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (reg_valid || busy) vcyc++;
        end
        check("disabled_no_traffic", vcyc, 32'd0);

        // Backpressure on the claim read and the handler, enable dropped in HANDLE.
        rd0 = rd_cnt; wr0 = wr_cnt;
        enable = 1;
        step();
        irq = 0;
        for (int i = 0; i < 3; i++) begin
            check("bp_rd_valid", {31'd0, reg_valid}, 32'd1);
            check("bp_rd_write", {31'd0, reg_write}, 32'd0);
            check("bp_rd_addr", reg_addr, CC);
            step();
        end
        reg_ready = 1; reg_rdata = 32'h7;
        step();
        reg_ready = 0;
        for (int i = 0; i < 4; i++) begin
            check("bp_hvalid", {31'd0, hdl_valid}, 32'd1);
            check("bp_hid", {25'd0, hdl_id}, 32'd7);
            step();
        end
        hdl_ready = 1;
        step();
        hdl_ready = 0; enable = 0;
        check("bp_handle_quiet", {30'd0, reg_valid, hdl_valid}, 32'd0);
        step();
        done = 1;
        step();
        done = 0;
        check("bp_wr_valid", {31'd0, reg_valid}, 32'd1);
        check("bp_wr_write", {31'd0, reg_write}, 32'd1);
        check("bp_wr_wdata", reg_wdata, 32'd7);
        reg_ready = 1;
        step();
        reg_ready = 0;
        wait_idle("bp_back_idle");
        check("bp_one_read", rd_cnt - rd0, 32'd1);
        check("bp_one_write", wr_cnt - wr0, 32'd1);
        check("bp_ccnt", {30'd0, claim_cnt}, 32'd2);

        // Error on the complete write; err_o stays set and the FSM returns to IDLE.
        do_txn(7'd33, 1'b1);
        check("cerr_err", {31'd0, err}, 32'd1);
        check("cerr_ccnt", {30'd0, claim_cnt}, 32'd3);

        // Counter saturation at 3.
        do_txn(7'd1, 1'b0);
        do_txn(7'd127, 1'b0);
        check("sat_ccnt", {30'd0, claim_cnt}, 32'd3);
        check("sat_scnt", {30'd0, spur_cnt}, 32'd1);

        // Reset asserted while in COMPLETE.
        irq = 1; enable = 1;
        step();
        irq = 0; reg_ready = 1; reg_rdata = 32'h3;
        step();
        reg_ready = 0; hdl_ready = 1;
        step();
        hdl_ready = 0; done = 1;
        step();
        done = 0;
        check("rc_pre_valid", {31'd0, reg_valid}, 32'd1);
        rst = 1;
        step();
        check("rc_valid", {31'd0, reg_valid}, 32'd0);
        check("rc_write", {31'd0, reg_write}, 32'd0);
        check("rc_wdata", reg_wdata, 32'd0);
        check("rc_wstrb", {28'd0, reg_wstrb}, 32'd0);
        check("rc_hvalid", {31'd0, hdl_valid}, 32'd0);
        check("rc_hid", {25'd0, hdl_id}, 32'd0);
        check("rc_busy", {31'd0, busy}, 32'd0);
        check("rc_err", {31'd0, err}, 32'd0);
        check("rc_cnts", {28'd0, claim_cnt, spur_cnt}, 32'd0);
        check("rc_addr", reg_addr, CC);
        rst = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
